// File: rtl/uart_imem_loader.sv
// UART (8N1) to instruction-memory loader: packs received bytes little-endian into 32-bit words.
// Define UART_PARITY_EN to receive 8E1 frames with an even-parity bit checked before the stop bit.
module uart_imem_loader #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata,
    output logic [ADDR_W:0]   word_cnt,
    output logic              busy,
    output logic              frame_err,
    output logic [2:0]        dbg_state
);

    localparam int CPB = CLK_HZ / BAUD;
    localparam int TW  = $clog2(CPB);
    localparam logic [TW-1:0]   T_HALF  = TW'(CPB / 2 - 1);
    localparam logic [TW-1:0]   T_FULL  = TW'(CPB - 1);
    localparam logic [TW-1:0]   T_ONE   = TW'(1);
    localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
`ifdef UART_PARITY_EN
        S_PARITY  = 3'd3,
`endif
        S_STOP    = 3'd4,
        S_RECOVER = 3'd5
    } state_t;

    logic              rx_meta_q;
    logic              rxs_q;
    state_t            state_q;
    logic [TW-1:0]     timer_q;
    logic [2:0]        bit_idx_q;
    logic [7:0]        shift_q;
    logic [1:0]        byte_idx_q;
    logic [23:0]       part_q;
    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [31:0]       wdata_q;
    logic [ADDR_W:0]   word_cnt_q;
    logic              busy_q;
    logic              frame_err_q;
    logic              stop_ok_d;
    logic              tick_half_d;
    logic              tick_full_d;
`ifdef UART_PARITY_EN
    logic              par_err_q;
`endif

    // rx is asynchronous; only rxs_q is allowed to steer the receiver.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
        end
    end

    always_comb begin
        tick_half_d = (timer_q == T_HALF);
        tick_full_d = (timer_q == T_FULL);
`ifdef UART_PARITY_EN
        stop_ok_d   = rxs_q & ~par_err_q;
`else
        stop_ok_d   = rxs_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            byte_idx_q  <= '0;
            part_q      <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            word_cnt_q  <= '0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            we_q <= 1'b0;
            // Address advances the cycle after the strobe so waddr is stable while we is high.
            if (we_q) begin
                waddr_q <= waddr_q + 1'b1;
                if (word_cnt_q != CNT_MAX) begin
                    word_cnt_q <= word_cnt_q + CNT_ONE;
                end
            end

            case (state_q)
                S_IDLE: begin
                    bit_idx_q <= '0;
                    timer_q   <= '0;
                    if (!rxs_q) begin
                        state_q <= S_START;
                        busy_q  <= 1'b1;
                    end
                end

                S_START: begin
                    if (tick_half_d) begin
                        timer_q <= '0;
                        if (!rxs_q) begin
                            state_q <= S_DATA;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        timer_q <= timer_q + T_ONE;
                    end
                end

                S_DATA: begin
                    if (tick_full_d) begin
                        timer_q <= '0;
                        shift_q <= {rxs_q, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        timer_q <= timer_q + T_ONE;
                    end
                end

`ifdef UART_PARITY_EN
                S_PARITY: begin
                    if (tick_full_d) begin
                        timer_q   <= '0;
                        par_err_q <= rxs_q ^ (^shift_q);
                        state_q   <= S_STOP;
                    end else begin
                        timer_q <= timer_q + T_ONE;
                    end
                end
`endif

                S_STOP: begin
                    if (tick_full_d) begin
                        timer_q <= '0;
                        if (stop_ok_d) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            if (byte_idx_q == 2'd3) begin
                                we_q       <= 1'b1;
                                wdata_q    <= {shift_q, part_q};
                                byte_idx_q <= 2'd0;
                            end else begin
                                case (byte_idx_q)
                                    2'd0:    part_q[7:0]   <= shift_q;
                                    2'd1:    part_q[15:8]  <= shift_q;
                                    default: part_q[23:16] <= shift_q;
                                endcase
                                byte_idx_q <= byte_idx_q + 2'd1;
                            end
                        end else begin
                            // A corrupt frame poisons the whole word being assembled.
                            frame_err_q <= 1'b1;
                            byte_idx_q  <= 2'd0;
                            state_q     <= S_RECOVER;
                        end
                    end else begin
                        timer_q <= timer_q + T_ONE;
                    end
                end

                S_RECOVER: begin
                    if (rxs_q) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign we        = we_q;
    assign waddr     = waddr_q;
    assign wdata     = wdata_q;
    assign word_cnt  = word_cnt_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Bench for uart_imem_loader: drives UART frames, predicts memory writes with a byte/word model.
`timescale 1ns/1ps
module tb_uart_imem_loader;
  localparam int CPB = 10;
  localparam int AW  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx  = 1'b1;
  logic          we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;
  logic [AW:0]   word_cnt;
  logic          busy;
  logic          frame_err;
  logic [2:0]    dbg_state;

  uart_imem_loader #(.CLK_HZ(1000000), .BAUD(100000), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .rx(rx), .we(we), .waddr(waddr), .wdata(wdata),
    .word_cnt(word_cnt), .busy(busy), .frame_err(frame_err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // scoreboard
  logic [31:0]   exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [AW:0]   exp_cnt_q[$];

  // reference model
  logic [7:0]    m_bytes[$];
  logic [AW-1:0] m_addr;
  int            m_cnt;
  logic          m_err;
  logic [31:0]   m_last;

  logic          mon_pend = 1'b0;
  logic [AW-1:0] mon_addr;
  logic [AW:0]   mon_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_bytes.delete();
    m_addr = '0;
    m_cnt  = 0;
    m_err  = 1'b0;
    m_last = 32'h0;
  endtask

  task automatic model_frame(input logic [7:0] d, input logic good);
    logic [AW:0] c;
    logic [31:0] w;
    if (!good) begin
      m_bytes.delete();
      m_err = 1'b1;
    end else begin
      m_bytes.push_back(d);
      if (m_bytes.size() == 4) begin
        w = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
        m_cnt = (m_cnt + 1 > (1 << AW)) ? (1 << AW) : m_cnt + 1;
        c = m_cnt[AW:0];
        exp_q.push_back(w);
        exp_addr_q.push_back(m_addr);
        exp_cnt_q.push_back(c);
        m_addr = m_addr + 1'b1;
        m_last = w;
        m_bytes.delete();
      end
    end
  endtask

  // write monitor
  always @(negedge clk) begin
    if (rst) begin
      mon_pend = 1'b0;
    end else begin
      if (mon_pend) begin
        check("waddr_after_we", waddr, mon_addr);
        check("word_cnt_after_we", word_cnt, mon_cnt);
        check("we_one_cycle", we, 0);
        mon_pend = 1'b0;
      end
      if (we === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("we_unexpected", we, 0);
        end else begin
          check("wdata", wdata, exp_q[0]);
          check("waddr_at_we", waddr, exp_addr_q[0]);
          mon_addr = exp_addr_q[0] + 1'b1;
          mon_cnt  = exp_cnt_q[0];
          mon_pend = 1'b1;
          void'(exp_q.pop_front());
          void'(exp_addr_q.pop_front());
          void'(exp_cnt_q.pop_front());
        end
      end
    end
  end

  // driver tasks
  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    model_frame(d, stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_PARITY_EN
    drive_bit(^d);
`endif
    drive_bit(stop_bit);
    if (!stop_bit) idle(2 * CPB);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++) begin
      send_frame(w[8*k +: 8], 1'b1);
      if (gap > 0) idle(gap);
    end
  endtask

  task automatic do_reset();
    check("pending_writes_at_reset", exp_q.size(), 0);
    rst = 1'b1;
    rx  = 1'b1;
    @(posedge clk);
    #1;
    check("rst_we", we, 0);
    check("rst_waddr", waddr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_word_cnt", word_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_err", frame_err, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #500000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w;
    model_reset();
    #1;

    // idle line after reset
    do_reset();
    repeat (100) begin
      @(negedge clk);
      check("idle_we", we, 0);
      check("idle_busy", busy, 0);
    end
    @(posedge clk);
    #1;
    check("idle_waddr", waddr, 0);
    check("idle_frame_err", frame_err, 0);
    check("idle_word_cnt", word_cnt, 0);

    // one known instruction word
    do_reset();
    send_word(32'h00500513, 3);
    idle(30);
    check("word1_writes_done", exp_q.size(), 0);
    check("word1_wdata", wdata, 32'h00500513);
    check("word1_waddr", waddr, 1);
    check("word1_cnt", word_cnt, 1);

    // five random words back-to-back: wrap and saturation
    do_reset();
    for (int i = 0; i < 5; i++) send_word($urandom, 0);
    idle(30);
    check("b2b_writes_done", exp_q.size(), 0);
    check("b2b_cnt_sat", word_cnt, m_cnt);
    check("b2b_waddr", waddr, m_addr);
    check("b2b_wdata_hold", wdata, m_last);

    // bad stop bit drops the partial word; error is sticky
    send_frame(8'hAA, 1'b1);
    send_frame($urandom_range(0, 255), 1'b0);
    check("err_set", frame_err, m_err);
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    send_frame(8'h03, 1'b1);
    send_frame(8'h04, 1'b1);
    idle(30);
    check("err_sticky", frame_err, 1);
    check("err_writes_done", exp_q.size(), 0);
    check("err_wdata", wdata, 32'h04030201);
    check("err_waddr", waddr, m_addr);

    // short low glitch, busy latency
    do_reset();
    rx = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("busy_before_3", busy, 0);
    @(posedge clk);
    #1;
    rx = 1'b1;
    @(negedge clk);
    check("busy_at_3", busy, 1);
    idle(20);
    check("glitch_busy_clear", busy, 0);
    check("glitch_no_err", frame_err, 0);
    w = $urandom;
    send_word(w, $urandom_range(0, 12));
    idle(30);
    check("glitch_writes_done", exp_q.size(), 0);
    check("glitch_wdata", wdata, w);
    check("glitch_waddr", waddr, 1);

    // reset in the middle of byte 2
    do_reset();
    send_word($urandom, $urandom_range(0, 8));
    send_frame($urandom_range(0, 255), 1'b0);
    send_frame($urandom_range(0, 255), 1'b1);
    send_frame($urandom_range(0, 255), 1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    check("pre_rst_err", frame_err, m_err);
    check("pre_rst_busy", busy, 1);
    check("pre_rst_waddr", waddr, m_addr);
    do_reset();
    idle(20);
    w = $urandom;
    send_word(w, $urandom_range(0, 8));
    idle(30);
    check("post_rst_writes_done", exp_q.size(), 0);
    check("post_rst_wdata", wdata, w);
    check("post_rst_waddr", waddr, 1);
    check("post_rst_cnt", word_cnt, 1);
    check("post_rst_err", frame_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
